// File: rtl/sim_result_monitor.sv
// sim_result_monitor
//   Watches NCH per-channel result codes during a bounded run and reports an
//   overall verdict: pass once every participating channel has reported pass,
//   fail on the first failing report, or timeout when the cycle budget runs out.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous, active-low reset
//   start      : arm pulse, acted on outside RUN only
//   ch_result  : per-channel code in [2i+1:2i]; 00 running, 10 pass, 01 fail, 11 illegal
//   ch_mask    : 1 = channel participates; captured on the start edge
//   result     : 00 idle/running, 10 pass, 01 fail, 11 timeout
//   busy       : high while running
//   done       : high in any terminal state
//   fail_ch    : lowest failing channel index of the failing cycle
//   pass_vec   : sticky per-channel pass flags for the current run
//   cycles     : running cycles elapsed in the current or last run
module sim_result_monitor #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 32,
  parameter int unsigned TIMEOUT = 1000000,
  localparam int unsigned FCW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2*NCH-1:0] ch_result,
  input  logic [NCH-1:0]   ch_mask,
  output logic [1:0]       result,
  output logic             busy,
  output logic             done,
  output logic [FCW-1:0]   fail_ch,
  output logic [NCH-1:0]   pass_vec,
  output logic [CW-1:0]    cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TMO
  } state_t;

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] pass_vec_q, pass_vec_d;
  logic [FCW-1:0] fail_ch_q, fail_ch_d;
  logic [CW-1:0]  cycles_q, cycles_d;

  logic [NCH-1:0] pass_now;
  logic [NCH-1:0] fail_vec;
  logic [FCW-1:0] fail_idx;

  // Code bit 0 set means 01 (fail) or 11 (illegal); both count as failures.
  always_comb begin
    pass_now = '0;
    fail_vec = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      pass_now[i] = mask_q[i] & ch_result[2*i+1] & ~ch_result[2*i];
      fail_vec[i] = mask_q[i] & ch_result[2*i];
    end
  end

  // Scan from the top down so the lowest failing index wins.
  always_comb begin
    fail_idx = '0;
    for (int unsigned i = NCH; i > 0; i--) begin
      if (fail_vec[i-1]) fail_idx = FCW'(i - 1);
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    pass_vec_d = pass_vec_q;
    fail_ch_d  = fail_ch_q;
    cycles_d   = cycles_q;
    case (state_q)
      S_RUN: begin
        pass_vec_d = pass_vec_q | pass_now;
        cycles_d   = (cycles_q == '1) ? cycles_q : cycles_q + CW'(1);
        // Priority: failure, then all-passed (including this cycle's passes), then timeout.
        if (|fail_vec) begin
          state_d   = S_FAIL;
          fail_ch_d = fail_idx;
        end else if ((pass_vec_d & mask_q) == mask_q) begin
          state_d = S_PASS;
        end else if (cycles_q == TMO_LAST) begin
          state_d = S_TMO;
        end
      end
      default: begin
        if (start) begin
          state_d    = S_RUN;
          mask_d     = ch_mask;
          pass_vec_d = '0;
          fail_ch_d  = '0;
          cycles_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      pass_vec_q <= '0;
      fail_ch_q  <= '0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      pass_vec_q <= pass_vec_d;
      fail_ch_q  <= fail_ch_d;
      cycles_q   <= cycles_d;
    end
  end

  always_comb begin
    result = 2'b00;
    case (state_q)
      S_PASS:  result = 2'b10;
      S_FAIL:  result = 2'b01;
      S_TMO:   result = 2'b11;
      default: result = 2'b00;
    endcase
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TMO);
  assign fail_ch  = fail_ch_q;
  assign pass_vec = pass_vec_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_sim_result_monitor.sv
module tb_sim_result_monitor;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned TMO = 20;

  logic          clk;
  logic          reset;
  logic          start;
  logic [7:0]    ch_result;
  logic [3:0]    ch_mask;
  logic [1:0]    result;
  logic          busy;
  logic          done;
  logic [1:0]    fail_ch;
  logic [3:0]    pass_vec;
  logic [CW-1:0] cycles;

  sim_result_monitor #(
    .NCH    (NCH),
    .CW     (CW),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ch_result(ch_result),
    .ch_mask  (ch_mask),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .fail_ch  (fail_ch),
    .pass_vec (pass_vec),
    .cycles   (cycles)
  );

  typedef struct packed {
    logic [1:0]    result;
    logic [1:0]    fail_ch;
    logic [3:0]    pass_vec;
    logic [CW-1:0] cycles;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] stim [0:31];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: on every rising done, pop the oldest expectation and compare.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("result",   32'(result),   32'(e.result));
        chk("fail_ch",  32'(fail_ch),  32'(e.fail_ch));
        chk("pass_vec", 32'(pass_vec), 32'(e.pass_vec));
        chk("cycles",   32'(cycles),   32'(e.cycles));
        chk("busy_off", 32'(busy),     32'd0);
      end
    end
    done_prev <= done;
  end

  task automatic clear_stim();
    for (int i = 0; i < 32; i++) stim[i] = 8'h00;
  endtask

  // Drives one run: arm with mask m, then apply stim[k] in RUN cycle k.
  task automatic run_case(input logic [3:0] m, input exp_t e, input bit mid_start);
    bit seen;
    seen = 1'b0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; ch_mask = m; ch_result = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      ch_result = (k < 32) ? stim[k] : 8'h00;
      start     = (mid_start && k == 2);
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0; ch_result = 8'h00;
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    // Terminal state must hold with idle inputs.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_result", 32'(result), 32'(e.result));
    chk("hold_cycles", 32'(cycles), 32'(e.cycles));
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; start = 1'b0; ch_result = 8'h00; ch_mask = 4'h0;
    clear_stim();
    #12;
    chk("rst_result",   32'(result),   32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_pass_vec", 32'(pass_vec), 32'd0);
    chk("rst_cycles",   32'(cycles),   32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_rst", 32'(busy), 32'd0);

    // ch1 and ch2 fail together in cycle 4 -> lowest index 1
    clear_stim(); stim[1] = 8'h02; stim[4] = 8'h14;
    e = '{result: 2'b01, fail_ch: 2'd1, pass_vec: 4'b0001, cycles: 16'd5};
    run_case(4'b1111, e, 1'b0);

    // Passes on cycles 3,5,5,7; start pulse mid-run is ignored; fail_ch cleared
    clear_stim(); stim[3] = 8'h02; stim[5] = 8'h28; stim[7] = 8'h80;
    e = '{result: 2'b10, fail_ch: 2'd0, pass_vec: 4'b1111, cycles: 16'd8};
    run_case(4'b1111, e, 1'b1);

    // Timeout: ch1 silent, masked ch2 fails
    clear_stim(); stim[2] = 8'h02; stim[3] = 8'h10;
    e = '{result: 2'b11, fail_ch: 2'd0, pass_vec: 4'b0001, cycles: 16'd20};
    run_case(4'b0011, e, 1'b0);

    // Masked ch1/ch3 report fail/illegal, ch0/ch2 pass
    clear_stim(); stim[1] = 8'h02; stim[2] = 8'hC4; stim[4] = 8'h20;
    e = '{result: 2'b10, fail_ch: 2'd0, pass_vec: 4'b0101, cycles: 16'd5};
    run_case(4'b0101, e, 1'b0);

    // Last pass lands in cycle TIMEOUT-1 -> pass wins over timeout
    clear_stim(); stim[0] = 8'h02; stim[5] = 8'h08; stim[10] = 8'h20; stim[19] = 8'h80;
    e = '{result: 2'b10, fail_ch: 2'd0, pass_vec: 4'b1111, cycles: 16'd20};
    run_case(4'b1111, e, 1'b0);

    // Same but last channel fails -> fail wins over timeout
    clear_stim(); stim[0] = 8'h02; stim[5] = 8'h08; stim[10] = 8'h20; stim[19] = 8'h40;
    e = '{result: 2'b01, fail_ch: 2'd3, pass_vec: 4'b0111, cycles: 16'd20};
    run_case(4'b1111, e, 1'b0);

    // Already-passed ch0 later reports illegal -> still a failure
    clear_stim(); stim[1] = 8'h02; stim[3] = 8'h03;
    e = '{result: 2'b01, fail_ch: 2'd0, pass_vec: 4'b0001, cycles: 16'd4};
    run_case(4'b0011, e, 1'b0);

    // Empty mask passes after one cycle regardless of codes
    clear_stim(); stim[0] = 8'hFF;
    e = '{result: 2'b10, fail_ch: 2'd0, pass_vec: 4'b0000, cycles: 16'd1};
    run_case(4'b0000, e, 1'b0);

    // Reset mid-run
    clear_stim();
    @(posedge clk); #1;
    start = 1'b1; ch_mask = 4'b1111;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ch_result = (k == 1) ? 8'h02 : 8'h00;
      @(posedge clk); #1;
    end
    chk("midrun_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_result",   32'(result),   32'd0);
    chk("mid_rst_busy",     32'(busy),     32'd0);
    chk("mid_rst_done",     32'(done),     32'd0);
    chk("mid_rst_fail_ch",  32'(fail_ch),  32'd0);
    chk("mid_rst_pass_vec", 32'(pass_vec), 32'd0);
    chk("mid_rst_cycles",   32'(cycles),   32'd0);
    ch_result = 8'h00;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_busy",   32'(busy),   32'd0);
    chk("post_rst_cycles", 32'(cycles), 32'd0);

    // Fresh run after reset counts from zero
    clear_stim(); stim[3] = 8'h02; stim[5] = 8'h28; stim[7] = 8'h80;
    e = '{result: 2'b10, fail_ch: 2'd0, pass_vec: 4'b1111, cycles: 16'd8};
    run_case(4'b1111, e, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sim_result_monitor.md
SIM_RESULT_MONITOR -- requirements
Module: sim_result_monitor

Interface
REQ-001 SHALL have parameter NCH, default 4: number of monitored result channels, range 1..32.
REQ-002 SHALL have parameter CW, default 32: width of the cycle counter.
REQ-003 SHALL have parameter TIMEOUT, default 1000000: cycle budget in RUN, range 1..2^CW-1.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: arm pulse; acted on only in IDLE, PASS, FAIL or TMO.
REQ-007 SHALL have port ch_result, input, 2*NCH: per-channel code in bits [2i+1:2i]; 00 running, 10 pass, 01 fail, 11 illegal.
REQ-008 SHALL have port ch_mask, input, NCH: 1 = channel participates; sampled once, at the start edge.
REQ-009 SHALL have port result, output, 2: 00 idle/running, 10 pass, 01 fail, 11 timeout.
REQ-010 SHALL have port busy, output, 1: high in RUN only.
REQ-011 SHALL have port done, output, 1: high in PASS, FAIL or TMO.
REQ-012 SHALL have port fail_ch, output, max(1,$clog2(NCH)): index of the first failing channel.
REQ-013 SHALL have port pass_vec, output, NCH: sticky per-channel pass flags for the current run.
REQ-014 SHALL have port cycles, output, CW: RUN cycles elapsed in the current or last run.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, PASS, FAIL, TMO; all outputs are registered or decoded from state.
REQ-016 IDLE/PASS/FAIL/TMO with start=1 SHALL go to RUN next cycle: latch ch_mask, clear pass_vec, fail_ch and cycles.
REQ-017 start in RUN SHALL be ignored.
REQ-018 In RUN, each cycle, for every unmasked channel: code 10 sets its pass_vec bit (sticky); code 01 or 11 is a failure.
REQ-019 Masked channels SHALL be ignored; their pass_vec bits stay 0.
REQ-020 A channel already in pass_vec that later shows 01/11 SHALL still count as a failure.
REQ-021 Any failure in RUN SHALL give FAIL next cycle; fail_ch = lowest failing index in that sampling cycle.
REQ-022 RUN SHALL give PASS next cycle when every unmasked channel's pass bit, including bits set this cycle, is 1 and there is no failure.
REQ-023 Failure and all-passed in the same cycle SHALL resolve to FAIL.
REQ-024 A latched mask of all zeros SHALL give PASS after exactly one RUN cycle.
REQ-025 cycles SHALL increment by 1 every RUN cycle and saturate at 2^CW-1.
REQ-026 RUN SHALL give TMO when cycles reaches TIMEOUT-1 in a cycle with no failure or all-passed; FAIL and PASS take priority over TMO in the same cycle.
REQ-027 PASS, FAIL and TMO SHALL hold all outputs stable until start or reset.
REQ-028 Latency SHALL be one cycle from the sampled ch_result to the result change.

Reset
REQ-029 reset=0 SHALL force IDLE immediately, from any state including mid-RUN.
REQ-030 reset=0 SHALL force result=00, busy=0, done=0, fail_ch=0, pass_vec=0, cycles=0, latched mask=0.
REQ-031 Leaving reset SHALL keep the block in IDLE until start is seen, on or after the first clk edge with reset=1.

Verification
REQ-032 Bench SHALL cover: NCH=4, mask=1111, start, then channels 0..3 report 10 on cycles 3,5,5,7 -> result=10, done=1, pass_vec=1111, cycles=8.
REQ-033 Bench SHALL cover: mask=1111, ch2 and ch1 report 01 in the same cycle -> result=01, fail_ch=1, next cycle.
REQ-034 Bench SHALL cover: TIMEOUT=20, mask=0011, ch1 never reports -> result=11 after 20 RUN cycles, pass_vec=0001 if ch0 passed.
REQ-035 Bench SHALL cover: mask=0101, masked ch1 reports 01 while ch0 and ch2 report 10 -> result=10.
REQ-036 Bench SHALL cover: in the cycle cycles=TIMEOUT-1, last channel reports 10 -> result=10, not 11; the same case with 01 -> result=01.
REQ-037 Bench SHALL cover: reset=0 asserted mid-RUN, then released, then start -> outputs at reset values immediately, then a fresh run with cycles restarting from 0.
